// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dmem_responder_pkg
// Description : Shared definitions for the data-memory responder and the MEM
//               stage: bus widths, reset level, big-endian byte-select
//               encodings, responder state encoding and a lane-mask helper.
// Revision    : 1.0  initial release
// ============================================================================
package dmem_responder_pkg;

  localparam int DataBus     = 32;
  localparam int DataAddrBus = 32;

  localparam logic [DataBus-1:0] ZeroWord  = '0;
  localparam logic               RstEnable = 1'b1;

  // Big-endian byte selects: bit 3 is the byte at addr[1:0] = 0,
  // which lives in data bits [31:24].
  localparam logic [3:0] SEL_WORD    = 4'b1111;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_B0      = 4'b1000;
  localparam logic [3:0] SEL_B1      = 4'b0100;
  localparam logic [3:0] SEL_B2      = 4'b0010;
  localparam logic [3:0] SEL_B3      = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Expand a 4-bit byte select into a 32-bit lane mask (sel bit n -> bits 8n+7:8n).
  function automatic logic [DataBus-1:0] sel_to_mask(input logic [3:0] sel);
    logic [DataBus-1:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) begin
      m[8*l +: 8] = {8{sel[l]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_sel_check.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sel_check
// Description : Combinational legality check of a data-memory request.
//               A request is legal when its word index lies inside the array
//               and the byte select matches the byte offset of the address.
//               Also produces the 32-bit lane mask (zero when illegal).
// Ports       : sel_i   - big-endian byte selects
//               addr_i  - byte address
//               legal_o - request is legal
//               mask_o  - lane mask of the selected bytes, 0 if illegal
// Revision    : 1.0  initial release
// ============================================================================
module dmem_sel_check
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic [3:0]             sel_i,
  input  logic [DataAddrBus-1:0] addr_i,
  output logic                   legal_o,
  output logic [DataBus-1:0]     mask_o
);

  logic w_pattern_ok;
  logic w_in_range;
  logic w_legal;

  // Word-index bits are irrelevant to legality; only the range check above them is.
  logic w_unused_addr;
  assign w_unused_addr = ^addr_i[DEPTH_LOG2+1:2];

  always_comb begin
    w_pattern_ok = 1'b0;
    case (sel_i)
      SEL_WORD:    w_pattern_ok = (addr_i[1:0] == 2'b00);
      SEL_HALF_HI: w_pattern_ok = (addr_i[1:0] == 2'b00);
      SEL_HALF_LO: w_pattern_ok = (addr_i[1:0] == 2'b10);
      SEL_B0:      w_pattern_ok = (addr_i[1:0] == 2'b00);
      SEL_B1:      w_pattern_ok = (addr_i[1:0] == 2'b01);
      SEL_B2:      w_pattern_ok = (addr_i[1:0] == 2'b10);
      SEL_B3:      w_pattern_ok = (addr_i[1:0] == 2'b11);
      default:     w_pattern_ok = 1'b0;
    endcase
  end

  // Word index < 2^DEPTH_LOG2 <=> every address bit above the index is zero.
  assign w_in_range = (addr_i[DataAddrBus-1:DEPTH_LOG2+2] == '0);
  assign w_legal    = w_pattern_ok & w_in_range;

  assign legal_o = w_legal;
  assign mask_o  = w_legal ? sel_to_mask(sel_i) : ZeroWord;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the MEM pipeline stage. Accepts one
//               request at a time, inserts WAIT_CYCLES wait states, performs a
//               byte-enabled read or write on an internal word array and
//               returns a single-cycle ack with read data or an error flag.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               req_i      - request valid (sampled in IDLE only)
//               we_i       - 1 = write, 0 = read
//               addr_i     - byte address
//               sel_i      - big-endian byte selects
//               wdata_i    - write data, lanes aligned to sel_i
//               ack_o      - one-cycle completion strobe
//               err_o      - illegal request flag, valid with ack_o
//               rdata_o    - masked read data, valid with ack_o
//               busy_o     - high whenever not IDLE
// Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [DataAddrBus-1:0] addr_i,
  input  logic [3:0]             sel_i,
  input  logic [DataBus-1:0]     wdata_i,
  output logic                   ack_o,
  output logic                   err_o,
  output logic [DataBus-1:0]     rdata_o,
  output logic                   busy_o
);

  localparam int         DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic                   ack_q;
  logic                   err_q;
  logic [DataBus-1:0]     rdata_q;

  // Latched request; inputs are ignored after acceptance.
  logic                   we_q;
  logic [DataAddrBus-1:0] addr_q;
  logic [3:0]             sel_q;
  logic [DataBus-1:0]     wdata_q;

  logic [DataBus-1:0]     mem_q [DEPTH];

  logic                   w_legal;
  logic [DataBus-1:0]     w_mask;
  logic [DEPTH_LOG2-1:0]  w_idx;
  logic                   w_access;
  logic                   w_do_write;
  logic                   err_d;
  logic [DataBus-1:0]     rdata_d;

  dmem_sel_check #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sel_check (
    .sel_i   (sel_q),
    .addr_i  (addr_q),
    .legal_o (w_legal),
    .mask_o  (w_mask)
  );

  assign w_idx    = addr_q[DEPTH_LOG2+1:2];
  assign w_access = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  // Reset at the access edge wins: the write is suppressed.
  assign w_do_write = (rst != RstEnable) && w_access && w_legal && we_q;

  assign err_d   = ~w_legal;
  assign rdata_d = (w_legal && !we_q) ? (mem_q[w_idx] & w_mask) : ZeroWord;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= ZeroWord;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= 4'd0;
      wdata_q <= ZeroWord;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            sel_q   <= sel_i;
            wdata_q <= wdata_i;
            cnt_q   <= WAIT_CNT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ack_q   <= 1'b1;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      mem_q[w_idx] <= (mem_q[w_idx] & ~w_mask) | (wdata_q & w_mask);
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard testbench for dmem_responder. A driver issues
//               directed and random requests, a reference model predicts each
//               response into a queue, and a monitor compares on every ack.
//               A second instance with WAIT_CYCLES=0 checks back-to-back
//               spacing with req held high.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DL = 10;
  localparam int W  = 2;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        ack_o, err_o, busy_o;
  logic [31:0] rdata_o;

  logic        req0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t        sbq[$];
  logic [31:0] mmodel[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .sel_i(sel), .wdata_i(wdata), .ack_o(ack_o), .err_o(err_o),
    .rdata_o(rdata_o), .busy_o(busy_o)
  );

  dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(1'b1), .addr_i(32'h0),
    .sel_i(4'hF), .wdata_i(32'h5A5A_5A5A), .ack_o(ack0), .err_o(err0),
    .rdata_o(rdata0), .busy_o(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: legality from the allowed (sel, offset) pairs,
  // memory as a sparse word map.
  function automatic exp_t model(input logic w, input logic [31:0] a,
                                 input logic [3:0] s, input logic [31:0] d);
    exp_t        e;
    int          idx;
    logic [1:0]  off;
    logic        ok;
    logic [31:0] m;
    idx = int'(a >> 2);
    off = a[1:0];
    ok  = (a[31:2] < (32'd1 << DL)) &&
          ((s == 4'hF && off == 2'd0) || (s == 4'hC && off == 2'd0) ||
           (s == 4'h3 && off == 2'd2) || (s == 4'h8 && off == 2'd0) ||
           (s == 4'h4 && off == 2'd1) || (s == 4'h2 && off == 2'd2) ||
           (s == 4'h1 && off == 2'd3));
    m   = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    e.cyc   = 0;
    e.err   = !ok;
    e.rdata = 32'h0;
    if (ok) begin
      if (w) begin
        if (!mmodel.exists(idx)) mmodel[idx] = 32'h0;
        mmodel[idx] = (mmodel[idx] & ~m) | (d & m);
      end else if (mmodel.exists(idx)) begin
        e.rdata = mmodel[idx] & m;
      end
    end
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge where ack is seen.
  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    int   n;
    exp_t e;
    req = 1'b1; we = w; addr = a; sel = s; wdata = d;
    n = 0;
    while (busy_o && n < 50) begin @(negedge clk); n++; end
    if (busy_o) begin
      chk("idle_timeout", 32'(busy_o), 32'h0);
      req = 1'b0;
      return;
    end
    e     = model(w, a, s, d);
    e.cyc = cyc + 2 + W;
    sbq.push_back(e);
    @(negedge clk);
    // Request already latched: scramble the inputs, they must not matter.
    we = 1'($urandom); addr = $urandom; sel = 4'($urandom); wdata = $urandom;
    n = 0;
    while (!ack_o && n < 50) begin @(negedge clk); n++; end
    if (!ack_o) chk("ack_timeout", 32'(ack_o), 32'h1);
    req = 1'b0;
  endtask

  // Monitor: compare every ack against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (ack_o === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_ack", 32'(ack_o), 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("err", 32'(err_o), 32'(e.err));
        chk("rdata", rdata_o, e.rdata);
        chk("ack_latency_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_in_resp", 32'(busy_o), 32'h1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int          last_ack, nacks;
    logic        prev_ack, seen;
    logic [3:0]  legal_sel [7];
    logic [1:0]  legal_off [7];
    legal_sel = '{4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};
    legal_off = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    // Reset with req high during reset: must not be accepted.
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'h1;
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_ack", 32'(ack_o), 32'h0);
      chk("reset_busy", 32'(busy_o), 32'h0);
      chk("reset_rdata", rdata_o, 32'h0);
    end

    // Give the words used by random traffic known contents.
    for (int i = 0; i < 8; i++) do_req(1'b1, 32'(i * 4), 4'hF, $urandom);

    // Directed cases.
    do_req(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h10, 4'hF, 32'h0);
    do_req(1'b1, 32'h13, 4'h1, 32'h0000_00AA);
    do_req(1'b0, 32'h10, 4'hF, 32'h0);
    do_req(1'b0, 32'h12, 4'h3, 32'h0);
    do_req(1'b1, 32'h11, 4'hC, 32'hFFFF_FFFF);
    do_req(1'b0, 32'h10, 4'hF, 32'h0);
    do_req(1'b0, 32'h0, 4'h0, 32'h0);
    do_req(1'b1, 32'(1 << (DL + 2)), 4'hF, 32'h1234_5678);
    do_req(1'b0, 32'(1 << (DL + 2)), 4'hF, 32'h0);
    do_req(1'b0, 32'h10, 4'hF, 32'h0);
    chk("directed_model_word", mmodel[4], 32'hDEAD_BEAA);

    // Abort: reset one cycle after acceptance of a write.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'h1234_5678;
    while (busy_o) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(ack_o), 32'h0);
    end
    do_req(1'b0, 32'h10, 4'hF, 32'h0);

    // Random traffic over words 0..7 plus occasional out-of-range words.
    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 9) == 0) a = 32'((1 << (DL + 2)) + $urandom_range(0, 1023) * 4);
      if ($urandom_range(0, 1) == 0) begin
        int k;
        k = $urandom_range(0, 6);
        s = legal_sel[k];
        a[1:0] = legal_off[k];
      end else begin
        s = 4'($urandom);
        a[1:0] = 2'($urandom);
      end
      do_req(1'($urandom), a, s, $urandom);
    end

    // Back-to-back on the zero-wait instance with req held high.
    @(negedge clk);
    req0 = 1'b1;
    last_ack = -1; nacks = 0; prev_ack = 1'b0; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (seen) chk("w0_busy_pattern", 32'(busy0), 32'(!prev_ack));
      if (ack0) begin
        chk("w0_err", 32'(err0), 32'h0);
        chk("w0_rdata", rdata0, 32'h0);
        if (last_ack >= 0) chk("w0_ack_spacing", 32'(cyc - last_ack), 32'd3);
        last_ack = cyc;
        nacks++;
        seen = 1'b1;
      end
      prev_ack = ack0;
    end
    req0 = 1'b0;
    chk("w0_ack_count", 32'(nacks >= 9), 32'h1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
